// File: rtl/serial_addsub_word.sv
// serial_addsub_word: LSB-first bit-serial adder/subtractor with parallel result.
// Optional macro SERIAL_ADDSUB_SUB_EN enables subtraction via the sub input.
module serial_addsub_word #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             s_bit,
  output logic             s_valid,
  output logic             cy,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, ovf_q;
  logic             ready_q, done_q;
  logic             accept, last, carry_nx;
  logic             run_bit, in_run;
  logic [WIDTH-1:0] b_ld;
  logic             c_ld;

  assign accept = (state_q == IDLE) && start;
  assign last   = (cnt_q == CW'(WIDTH - 1));

  assign carry_nx = (a_sh_q[0] & b_sh_q[0])
                  | (a_sh_q[0] & carry_q)
                  | (b_sh_q[0] & carry_q);

  assign run_bit = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;

`ifdef SERIAL_ADDSUB_SUB_EN
  // Subtraction is a + ~b + 1: invert B and seed the carry.
  assign b_ld = sub ? ~b : b;
  assign c_ld = sub;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_ld = b;
  assign c_ld = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Serial outputs: combinational from registers only
  always_comb begin
    in_run  = (state_q == RUN);
    s_valid = in_run;
    s_bit   = in_run & run_bit;
  end

  // Operand shifters, carry, counter and result capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_sh_q  <= a;
      b_sh_q  <= b_ld;
      carry_q <= c_ld;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state_q == RUN) begin
      a_sh_q  <= a_sh_q >> 1;
      b_sh_q  <= b_sh_q >> 1;
      carry_q <= carry_nx;
      cnt_q   <= cnt_q + 1'b1;
      sum_q   <= {run_bit, sum_q[WIDTH-1:1]};
      if (last) begin
        // carry_q here is the carry into the MSB
        cout_q <= carry_nx;
        ovf_q  <= carry_q ^ carry_nx;
      end
    end
  end

  // Registered handshake flags derived from the upcoming state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      ready_q <= (state_d == IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign cy    = carry_q;
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_addsub_word.sv
// tb_serial_addsub_word: directed and random checks of serial_addsub_word.
// Reference results come from plain integer arithmetic on the operands.
module tb_serial_addsub_word;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready, s_bit, s_valid, cy;
  logic [W-1:0] sum;
  logic         cout, ovf, done;

  int n_assert = 0;
  int n_fail   = 0;

  serial_addsub_word #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .sub     (sub),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .s_bit   (s_bit),
    .s_valid (s_valid),
    .cy      (cy),
    .sum     (sum),
    .cout    (cout),
    .ovf     (ovf),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: result, carry-out, overflow and per-bit carry-in
  task automatic model(input int av, input int bv, input bit sv,
                       output int rs, output bit rc, output bit ro,
                       output int cin_k[W]);
    int  sa, sb, sr, bb, ci, m;
    bit  do_sub;
`ifdef SERIAL_ADDSUB_SUB_EN
    do_sub = sv;
`else
    do_sub = 1'b0;
`endif
    sa = (av >= 128) ? av - 256 : av;
    sb = (bv >= 128) ? bv - 256 : bv;
    if (do_sub) begin
      rs = (av - bv + 256) % 256;
      rc = (av >= bv);
      sr = sa - sb;
      bb = 255 - bv;
      ci = 1;
    end else begin
      rs = (av + bv) % 256;
      rc = (av + bv) > 255;
      sr = sa + sb;
      bb = bv;
      ci = 0;
    end
    ro = (sr > 127) || (sr < -128);
    for (int k = 0; k < W; k++) begin
      m = (1 << k) - 1;
      cin_k[k] = (((av & m) + (bb & m) + ci) >> k) & 1;
    end
  endtask

  // Issue one operation from a negedge; returns at the negedge after done.
  task automatic run_op(input int av, input int bv, input bit sv,
                        input bit glitch);
    int rs;
    bit rc, ro;
    int ck[W];
    model(av, bv, sv, rs, rc, ro, ck);
    check("ready_idle", 32'(ready), 32'd1);
    start = 1'b1;
    a = W'(av);
    b = W'(bv);
    sub = sv;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~a;
    b = ~b;
    sub = ~sub;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      check("s_valid", 32'(s_valid), 32'd1);
      check($sformatf("s_bit%0d", k), 32'(s_bit), 32'((rs >> k) & 1));
      check($sformatf("cy%0d", k), 32'(cy), 32'(ck[k]));
      check("done_run", 32'(done), 32'd0);
      check("ready_run", 32'(ready), 32'd0);
      if (glitch && k == 3) begin
        start = 1'b1;
        a = W'($urandom);
        b = W'($urandom);
      end
      if (glitch && k == 5) start = 1'b0;
    end
    @(negedge clk);
    check("done_hi", 32'(done), 32'd1);
    check("sum", 32'(sum), 32'(rs));
    check("cout", 32'(cout), 32'(rc));
    check("ovf", 32'(ovf), 32'(ro));
    check("s_valid_done", 32'(s_valid), 32'd0);
    @(negedge clk);
    check("done_lo", 32'(done), 32'd0);
    check("ready_back", 32'(ready), 32'd1);
    check("sum_hold", 32'(sum), 32'(rs));
  endtask

  initial begin
    #12;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cy", 32'(cy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_op(32'h5A, 32'h33, 1'b0, 1'b0);
    check("d1_sum", 32'(sum), 32'h8D);
    check("d1_cout", 32'(cout), 32'd0);
    check("d1_ovf", 32'(ovf), 32'd1);

    run_op(32'hFF, 32'h01, 1'b0, 1'b0);
    check("d2_sum", 32'(sum), 32'h00);
    check("d2_cout", 32'(cout), 32'd1);
    check("d2_ovf", 32'(ovf), 32'd0);

`ifdef SERIAL_ADDSUB_SUB_EN
    run_op(32'h10, 32'h20, 1'b1, 1'b0);
    check("s1_sum", 32'(sum), 32'hF0);
    check("s1_cout", 32'(cout), 32'd0);
    check("s1_ovf", 32'(ovf), 32'd0);
    run_op(32'h80, 32'h01, 1'b1, 1'b0);
    check("s2_sum", 32'(sum), 32'h7F);
    check("s2_cout", 32'(cout), 32'd1);
    check("s2_ovf", 32'(ovf), 32'd1);
`else
    run_op(32'h10, 32'h20, 1'b1, 1'b0);
    check("n1_sum", 32'(sum), 32'h30);
    check("n1_cout", 32'(cout), 32'd0);
`endif

    run_op(32'h3C, 32'h41, 1'b0, 1'b1);

    for (int i = 0; i < 20; i++) begin
      run_op(int'($urandom_range(255)), int'($urandom_range(255)),
             1'($urandom), 1'b0);
    end

    // Abort mid-operation with asynchronous reset
    start = 1'b1;
    a = 8'hAB;
    b = 8'h12;
    sub = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    check("ab_ready", 32'(ready), 32'd1);
    check("ab_sum", 32'(sum), 32'd0);
    check("ab_cout", 32'(cout), 32'd0);
    check("ab_ovf", 32'(ovf), 32'd0);
    check("ab_done", 32'(done), 32'd0);
    check("ab_valid", 32'(s_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (W + 4) begin
      @(negedge clk);
      check("ab_nodone", 32'(done), 32'd0);
    end
    run_op(32'h01, 32'h01, 1'b0, 1'b0);
    check("ab_next_sum", 32'(sum), 32'h02);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
